// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - state type, blank code and leading-zero helper for bcd_scan_mux
// lz_mask exists only when BCD_SCAN_LZ_BLANK_EN is defined.
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

`ifdef BCD_SCAN_LZ_BLANK_EN
  function automatic logic [3:0] lz_mask(input logic [3:0] digit, input logic keep);
    return keep ? digit : BCD_BLANK;
  endfunction
`endif

endpackage

// File: rtl/bcd_scan_mux.sv
// rtl/bcd_scan_mux.sv - time-multiplexed 7-segment scan controller with per-slot blanking gap
// BCD_SCAN_LZ_BLANK_EN: replace leading zeros with the blank code at snapshot time.
module bcd_scan_mux
  import bcd_scan_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_i,
  output logic [3:0]            bcd_o,
  output logic [N_DIGITS-1:0]   digit_sel_o,
  output logic                  blank_o,
  output logic                  frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]   snap_q, snap_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [N_DIGITS-1:0]     sel_q, sel_d;
  logic                    blank_q, blank_d;
  logic                    frame_q, frame_d;
  logic [4*N_DIGITS-1:0]   capture;

`ifdef BCD_SCAN_LZ_BLANK_EN
  // Walk down from the top digit; a digit is kept once any digit at or above it is non-zero.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    capture = digits_i;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      seen = seen | (digits_i[4*k +: 4] != 4'h0);
      capture[4*k +: 4] = lz_mask(digits_i[4*k +: 4], seen);
    end
  end
`else
  assign capture = digits_i;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    frame_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          snap_d  = capture;
          frame_d = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              snap_d  = capture;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    bcd_d   = BCD_BLANK;
    sel_d   = '0;
    blank_d = 1'b1;
    if (state_d == SHOW) begin
      blank_d = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) begin
          bcd_d    = snap_d[4*k +: 4];
          sel_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      bcd_q   <= BCD_BLANK;
      sel_q   <= '0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
    end
  end

  assign bcd_o       = bcd_q;
  assign digit_sel_o = sel_q;
  assign blank_o     = blank_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb/tb_bcd_scan_mux.sv - scoreboard bench for bcd_scan_mux (N=4, REFRESH_DIV=8, BLANK_CYCLES=2)
// Expected output per cycle is queued with the stimulus and compared one cycle at a time.
module tb_bcd_scan_mux;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  bcd;
  logic [3:0]  sel;
  logic        blank;
  logic        frame;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  string       phase = "init";
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  bcd_scan_mux #(
    .N_DIGITS    (4),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits_i   (digits),
    .bcd_o      (bcd),
    .digit_sel_o(sel),
    .blank_o    (blank),
    .frame_o    (frame)
  );

  task automatic push_rec(input logic [3:0] b, input logic [3:0] s, input logic bl, input logic fr);
    exp_q.push_back({b, s, bl, fr});
  endtask

  task automatic push_blank(input int n, input logic fr);
    for (int i = 0; i < n; i++) push_rec(4'hF, 4'b0000, 1'b1, (i == 0) ? fr : 1'b0);
  endtask

  task automatic push_show(input logic [3:0] b, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) push_rec(b, s, 1'b0, 1'b0);
  endtask

  task automatic push_slot(input logic [3:0] b, input logic [3:0] s, input logic fr);
    push_blank(BC, fr);
    push_show(b, s, RD - BC);
  endtask

  task automatic drain();
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_v = exp_q.pop_front();
      obs_v = {bcd, sel, blank, frame};
      total++;
      assert (obs_v === exp_v) else begin
        bad++;
        $error("FAIL %s cyc=%0d got bcd=%h sel=%b blank=%b frame=%b exp bcd=%h sel=%b blank=%b frame=%b",
               phase, cyc, obs_v[9:6], obs_v[5:2], obs_v[1], obs_v[0],
               exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  initial begin
    logic [9:0] rst_obs;
    rst_n  = 1'b0;
    en     = 1'b0;
    digits = 16'h0000;

    phase = "reset";
    push_blank(3, 1'b0);
    drain();
    rst_n = 1'b1;

    phase = "idle";
    push_blank(20, 1'b0);
    drain();

    phase = "scan_order";
    digits = 16'h4321;
    en     = 1'b1;
    push_slot(4'h1, 4'b0001, 1'b1);
    push_slot(4'h2, 4'b0010, 1'b0);
    push_slot(4'h3, 4'b0100, 1'b0);
    push_slot(4'h4, 4'b1000, 1'b0);
    drain();

    phase = "snapshot";
    push_slot(4'h1, 4'b0001, 1'b1);
    push_blank(BC, 1'b0);
    push_show(4'h2, 4'b0010, 2);
    drain();
    digits = 16'h9876;
    push_show(4'h2, 4'b0010, RD - BC - 2);
    push_slot(4'h3, 4'b0100, 1'b0);
    push_slot(4'h4, 4'b1000, 1'b0);
    drain();

    phase = "new_frame";
    push_slot(4'h6, 4'b0001, 1'b1);
    push_slot(4'h7, 4'b0010, 1'b0);
    push_blank(BC, 1'b0);
    push_show(4'h8, 4'b0100, 3);
    drain();

    phase = "en_drop";
    en = 1'b0;
    push_blank(3, 1'b0);
    drain();

    phase = "re_enable";
    digits = 16'h1234;
    en     = 1'b1;
    push_slot(4'h4, 4'b0001, 1'b1);
    push_blank(BC, 1'b0);
    push_show(4'h3, 4'b0010, 3);
    drain();

    phase = "async_reset";
    #2;
    rst_n = 1'b0;
    #1;
    rst_obs = {bcd, sel, blank, frame};
    total++;
    assert (rst_obs === {4'hF, 4'b0000, 1'b1, 1'b0}) else begin
      bad++;
      $error("FAIL async_reset got bcd=%h sel=%b blank=%b frame=%b exp bcd=f sel=0000 blank=1 frame=0",
             rst_obs[9:6], rst_obs[5:2], rst_obs[1], rst_obs[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    phase = "after_reset";
    push_slot(4'h4, 4'b0001, 1'b1);
    drain();

    phase = "lz_0050";
    en = 1'b0;
    push_blank(1, 1'b0);
    drain();
    digits = 16'h0050;
    en     = 1'b1;
    push_slot(4'h0, 4'b0001, 1'b1);
    drain();
    digits = 16'h0000;
    push_slot(4'h5, 4'b0010, 1'b0);
`ifdef BCD_SCAN_LZ_BLANK_EN
    push_slot(4'hF, 4'b0100, 1'b0);
    push_slot(4'hF, 4'b1000, 1'b0);
`else
    push_slot(4'h0, 4'b0100, 1'b0);
    push_slot(4'h0, 4'b1000, 1'b0);
`endif
    drain();

    phase = "lz_0000";
    push_slot(4'h0, 4'b0001, 1'b1);
`ifdef BCD_SCAN_LZ_BLANK_EN
    push_slot(4'hF, 4'b0010, 1'b0);
    push_slot(4'hF, 4'b0100, 1'b0);
    push_slot(4'hF, 4'b1000, 1'b0);
`else
    push_slot(4'h0, 4'b0010, 1'b0);
    push_slot(4'h0, 4'b0100, 1'b0);
    push_slot(4'h0, 4'b1000, 1'b0);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_mux.md
# bcd_scan_mux

Time-multiplexed scan controller for an N-digit 7-segment display. It snapshots a packed vector of BCD digits once per frame and presents one digit at a time on a 4-bit BCD output, together with a one-hot digit-enable. Each digit slot begins with a blanking gap to prevent ghosting. It sits directly upstream of `dec_7_seg_dec`: `bcd_o` drives its `bcd` input, and `digit_sel_o` drives the digit common lines.

## Interface
- `N_DIGITS`, default 4: number of display digits; legal range ≥ 2.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: blanking cycles at the start of each slot; legal range ≥ 1.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  scan enable; level-sensitive.
- `digits_i`  in  4*N_DIGITS  packed BCD; digit k is at `[4k+3:4k]`; digit 0 is the least significant.
- `bcd_o`  out  4  BCD to the decoder; 4'hF means blank.
- `digit_sel_o`  out  N_DIGITS  one-hot, active-high digit enable; all zero while blanking.
- `blank_o`  out  1  high when no digit is driven.
- `frame_o`  out  1  one-cycle pulse on the cycle `digits_i` is snapshotted.

## Operation
- States: IDLE, BLANK, SHOW.
- All outputs are registered. Reset values: `bcd_o`=4'hF, `digit_sel_o`=0, `blank_o`=1, `frame_o`=0; state=IDLE, digit index=0, slot counter=0.
- IDLE:
  - Outputs are at their blank values.
  - On `en`=1, go to BLANK with index 0 and snapshot `digits_i`.
- BLANK:
  - Holds for `BLANK_CYCLES` cycles.
  - Outputs: `bcd_o`=4'hF, `digit_sel_o`=0, `blank_o`=1.
  - Then go to SHOW.
- SHOW:
  - Holds for `REFRESH_DIV`−`BLANK_CYCLES` cycles.
  - Outputs: `bcd_o` = snapshot digit[index], `digit_sel_o` = 1<<index, `blank_o`=0.
  - Then go to BLANK with index+1.
- Wrap-around: after index `N_DIGITS`−1, the next slot uses index 0 and takes a new snapshot. `frame_o` pulses on that cycle.
- Snapshot: `digits_i` is captured only at frame start. Changes mid-frame appear next frame, so there is no tearing.
- Codes 4'hA–4'hF pass through unmodified. The decoder renders them blank.
- `en` deasserted in any state: IDLE on the next edge, outputs blanked, index and counter cleared. Re-enabling restarts at digit 0 with a fresh snapshot.
- `rst_n` asserted mid-slot: outputs return to their reset values immediately (asynchronously).

## Timing
- `en` sampled high in IDLE at edge t:
  - At t+1: state=BLANK, `frame_o`=1 for one cycle, snapshot taken.
  - At t+1+`BLANK_CYCLES`: digit 0 is driven.
- Slot period is exactly `REFRESH_DIV` cycles. Frame period is `N_DIGITS`·`REFRESH_DIV` cycles.
- `frame_o` recurs every frame period while `en`=1.
- The slot counter is sized $clog2(`REFRESH_DIV`) bits. The index counter is sized $clog2(`N_DIGITS`) bits; for non-power-of-two `N_DIGITS`, it wraps explicitly at `N_DIGITS`−1.
- `digit_sel_o` and `bcd_o` change on the same edge. `digit_sel_o` never has more than one bit set.

## Configuration
- Macro: `BCD_SCAN_LZ_BLANK_EN`.
- Defined: leading-zero suppression.
  - At snapshot time, every digit above the highest non-zero digit is replaced by 4'hF.
  - Digit 0 is always shown, so all zeros displays a single "0".
  - Suppressed digits still occupy their slot, with `digit_sel_o` asserted and `bcd_o`=4'hF; frame timing is unchanged.
- Undefined: all digits are shown as snapshotted, and the mask logic is absent.

## Structure
- Package `bcd_scan_pkg` holds:
  - typedef `scan_state_e` (IDLE, BLANK, SHOW);
  - constant `BCD_BLANK` = 4'hF;
  - function `lz_mask` for leading-zero suppression, compiled under the macro.
- No sub-module; the slot and index counters are inline.
- The top level instantiates `bcd_scan_mux` alongside `dec_7_seg_dec`; the decoder is not instantiated inside this block.

## Test plan
All scenarios use `N_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset and idle: hold `rst_n`=0, then `en`=0 for 20 cycles -> `bcd_o`=F, `digit_sel_o`=0000, `blank_o`=1, `frame_o`=0 throughout.
- Scan order: `digits_i`=16'h4321, `en`=1 ->
  - `frame_o` pulses once;
  - per slot, 2 blank cycles then 6 cycles showing 1/0001, 2/0010, 3/0100, 4/1000;
  - `frame_o` repeats every 32 cycles.
- Snapshot: change `digits_i` from 16'h4321 to 16'h9876 during digit 1 -> the rest of the frame shows 3, 4; the next frame shows 6, 7, 8, 9.
- Enable drop: deassert `en` during SHOW of digit 2 -> blank outputs on the next edge. Re-assert `en` -> restart at digit 0 with a new `frame_o`.
- Async reset: pulse `rst_n` low mid-SHOW between clock edges -> outputs reach reset values before the next edge; scan restarts from IDLE.
- Leading-zero blanking (`BCD_SCAN_LZ_BLANK_EN` defined):
  - 16'h0050 -> digits shown 0, 5, F, F;
  - 16'h0000 -> 0, F, F, F;
  - with the macro undefined, 16'h0050 -> 0, 5, 0, 0.
